// File: rtl/vec_pkg.sv
// ---------------------------------------------------------------------------
// vec_pkg
// Shared constants, state encoding and element-select helper for the vector
// memory sequencing stages.
//   NUM_LANES : elements per vector
//   ELEM_W    : element / memory word width
//   VEC_W     : full vector width
//   IDX_W     : width of an element index
// ---------------------------------------------------------------------------
package vec_pkg;

   localparam int unsigned NUM_LANES = 4;
   localparam int unsigned ELEM_W    = 16;
   localparam int unsigned VEC_W     = NUM_LANES * ELEM_W;
   localparam int unsigned IDX_W     = $clog2(NUM_LANES);

   typedef enum logic [1:0] {
      IDLE,
      XFER,
      DRAIN,
      DONE
   } vms_state_t;

   // Element i of a packed vector: bits [ELEM_W*i + ELEM_W-1 : ELEM_W*i].
   function automatic logic [ELEM_W-1:0] elem(input logic [VEC_W-1:0] vec,
                                              input logic [IDX_W-1:0] i);
      return vec[ELEM_W*i +: ELEM_W];
   endfunction

endpackage

// File: rtl/vec_elem_counter.sv
// ---------------------------------------------------------------------------
// vec_elem_counter
// Element index counter shared by the vector sequencing stages.
//   clk    : system clock, rising edge
//   reset  : asynchronous, active-high reset
//   clr_i  : synchronous clear to 0 (wins over en_i)
//   en_i   : advance the index by one, wrapping after LANES-1
//   idx_o  : current element index
//   last_o : index is at LANES-1
// ---------------------------------------------------------------------------
module vec_elem_counter
   import vec_pkg::*;
#(
   parameter int unsigned LANES = NUM_LANES
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     clr_i,
   input  logic                     en_i,
   output logic [$clog2(LANES)-1:0] idx_o,
   output logic                     last_o
);

   localparam int unsigned W = $clog2(LANES);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i) begin
         cnt_d = (cnt_q == W'(LANES - 1)) ? '0 : cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign idx_o  = cnt_q;
   assign last_o = (cnt_q == W'(LANES - 1));

endmodule

// File: rtl/vec_mem_serializer.sv
// ---------------------------------------------------------------------------
// vec_mem_serializer
// Scatters a 4-lane vector result element-by-element into a word-addressed
// synchronous data memory (store), or gathers consecutive memory words into
// a vector for register write-back (load).
//   clk        : system clock, rising edge
//   reset      : asynchronous, active-high reset
//   start      : transfer request, accepted only when busy=0
//   is_load    : 1 = gather, 0 = scatter (sampled with start)
//   base_addr  : word address of element 0 (sampled with start)
//   wdata      : vector to store (sampled with start)
//   busy       : transfer in progress
//   done       : one-cycle completion pulse
//   rdata      : gathered vector, valid while done=1, held until next load
//   mem_addr   : memory word address
//   mem_we     : memory write enable
//   mem_wdata  : memory write data
//   mem_rdata  : memory read data, one cycle after its address
// ---------------------------------------------------------------------------
module vec_mem_serializer #(
   parameter int unsigned ADDR_W    = 16,
   parameter int unsigned ELEM_W    = 16,
   parameter int unsigned NUM_LANES = 4
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          start,
   input  logic                          is_load,
   input  logic [ADDR_W-1:0]             base_addr,
   input  logic [NUM_LANES*ELEM_W-1:0]   wdata,
   output logic                          busy,
   output logic                          done,
   output logic [NUM_LANES*ELEM_W-1:0]   rdata,
   output logic [ADDR_W-1:0]             mem_addr,
   output logic                          mem_we,
   output logic [ELEM_W-1:0]             mem_wdata,
   input  logic [ELEM_W-1:0]             mem_rdata
);

   import vec_pkg::*;

   localparam int unsigned VEC_BITS = NUM_LANES * ELEM_W;
   localparam int unsigned IDX_BITS = $clog2(NUM_LANES);

   vms_state_t            state_q, state_d;
   logic                  ld_q, ld_d;
   logic [ADDR_W-1:0]     base_q, base_d;
   logic [VEC_BITS-1:0]   wvec_q, wvec_d;
   logic [VEC_BITS-1:0]   rvec_q, rvec_d;

   logic [IDX_BITS-1:0]   idx;
   logic                  idx_last;
   logic                  accept;
   logic                  cnt_en;
   logic                  cap_en;
   logic [IDX_BITS-1:0]   cap_idx;

   vec_elem_counter #(
      .LANES (NUM_LANES)
   ) u_idx (
      .clk    (clk),
      .reset  (reset),
      .clr_i  (accept),
      .en_i   (cnt_en),
      .idx_o  (idx),
      .last_o (idx_last)
   );

   // Next state, memory interface and capture control.
   // Read data lags its address by one cycle, so while issuing element idx
   // the word for element idx-1 is on mem_rdata; DRAIN picks up the last one.
   always_comb begin
      state_d   = state_q;
      accept    = 1'b0;
      cnt_en    = 1'b0;
      cap_en    = 1'b0;
      cap_idx   = '0;
      busy      = 1'b0;
      done      = 1'b0;
      mem_addr  = '0;
      mem_we    = 1'b0;
      mem_wdata = '0;

      unique case (state_q)
         IDLE: begin
            if (start) begin
               accept  = 1'b1;
               state_d = XFER;
            end
         end
         XFER: begin
            busy      = 1'b1;
            cnt_en    = 1'b1;
            mem_addr  = base_q + ADDR_W'(idx);
            mem_we    = ~ld_q;
            mem_wdata = elem(wvec_q, idx);
            if (ld_q && (idx != '0)) begin
               cap_en  = 1'b1;
               cap_idx = idx - 1'b1;
            end
            if (idx_last) begin
               state_d = ld_q ? DRAIN : DONE;
            end
         end
         DRAIN: begin
            busy    = 1'b1;
            cap_en  = 1'b1;
            cap_idx = IDX_BITS'(NUM_LANES - 1);
            state_d = DONE;
         end
         DONE: begin
            done = 1'b1;
            if (start) begin
               accept  = 1'b1;
               state_d = XFER;
            end else begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Request latches and lane-by-lane gather register.
   always_comb begin
      ld_d   = ld_q;
      base_d = base_q;
      wvec_d = wvec_q;
      rvec_d = rvec_q;
      if (accept) begin
         ld_d   = is_load;
         base_d = base_addr;
         wvec_d = wdata;
      end
      for (int unsigned i = 0; i < NUM_LANES; i++) begin
         if (cap_en && (cap_idx == IDX_BITS'(i))) begin
            rvec_d[i*ELEM_W +: ELEM_W] = mem_rdata;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ld_q   <= 1'b0;
         base_q <= '0;
         wvec_q <= '0;
         rvec_q <= '0;
      end else begin
         ld_q   <= ld_d;
         base_q <= base_d;
         wvec_q <= wvec_d;
         rvec_q <= rvec_d;
      end
   end

   assign rdata = rvec_q;

endmodule

// File: tb/tb_vec_mem_serializer.sv
module tb_vec_mem_serializer;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        start = 1'b0;
   logic        is_load = 1'b0;
   logic [15:0] base_addr = '0;
   logic [63:0] wdata = '0;
   logic        busy;
   logic        done;
   logic [63:0] rdata;
   logic [15:0] mem_addr;
   logic        mem_we;
   logic [15:0] mem_wdata;
   logic [15:0] mem_rdata = '0;

   logic [15:0] mem [0:65535];

   int total = 0;
   int bad   = 0;
   int lat;

   typedef struct { logic [15:0] a; logic [15:0] d; } wr_t;
   typedef struct { logic ld; logic [63:0] rd; } xf_t;
   wr_t wq[$];
   xf_t xq[$];
   wr_t mon_w;
   xf_t mon_x;

   vec_mem_serializer #(
      .ADDR_W    (16),
      .ELEM_W    (16),
      .NUM_LANES (4)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .is_load   (is_load),
      .base_addr (base_addr),
      .wdata     (wdata),
      .busy      (busy),
      .done      (done),
      .rdata     (rdata),
      .mem_addr  (mem_addr),
      .mem_we    (mem_we),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata)
   );

   always #5 clk = ~clk;

   // Synchronous memory model: write-enable store, registered read.
   always @(posedge clk) begin
      if (mem_we === 1'b1) mem[mem_addr] <= mem_wdata;
      mem_rdata <= mem[mem_addr];
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Scoreboard: each write and each done pulse pops its expectation.
   always @(negedge clk) begin
      if (mem_we === 1'b1) begin
         if (wq.size() == 0) begin
            chk("unexp_we", 64'(mem_we), 64'd0);
         end else begin
            mon_w = wq.pop_front();
            chk("wr_addr", 64'(mem_addr), 64'(mon_w.a));
            chk("wr_data", 64'(mem_wdata), 64'(mon_w.d));
         end
      end
      if (done === 1'b1) begin
         if (xq.size() == 0) begin
            chk("unexp_done", 64'(done), 64'd0);
         end else begin
            mon_x = xq.pop_front();
            if (mon_x.ld) chk("ld_rdata", rdata, mon_x.rd);
         end
      end
   end

   // Called at a negedge; the following posedge is the accept edge.
   task automatic drive_start(input logic ld, input logic [15:0] base,
                              input logic [63:0] data, input logic [63:0] exp_rd);
      wr_t w;
      xf_t x;
      start     = 1'b1;
      is_load   = ld;
      base_addr = base;
      wdata     = data;
      if (!ld) begin
         for (int i = 0; i < 4; i++) begin
            w.a = base + 16'(i);
            w.d = data[i*16 +: 16];
            wq.push_back(w);
         end
      end
      x.ld = ld;
      x.rd = exp_rd;
      xq.push_back(x);
      @(negedge clk);
      start = 1'b0;
   endtask

   // c0 = cycle number (after the accept edge) of the current negedge.
   task automatic wait_done(input int c0, output int n);
      n = c0;
      while (done !== 1'b1 && n < 20) begin
         chk("busy_in_xfer", 64'(busy), 64'd1);
         @(negedge clk);
         n++;
      end
      chk("done_seen", 64'(done), 64'd1);
      chk("busy_at_done", 64'(busy), 64'd0);
   endtask

   initial begin
      reset = 1'b1;
      #1;
      chk("rst_busy",  64'(busy), 64'd0);
      chk("rst_done",  64'(done), 64'd0);
      chk("rst_we",    64'(mem_we), 64'd0);
      chk("rst_addr",  64'(mem_addr), 64'd0);
      chk("rst_wdata", 64'(mem_wdata), 64'd0);
      chk("rst_rdata", rdata, 64'd0);

      mem[16'h0200] = 16'hAAAA;
      mem[16'h0201] = 16'hBBBB;
      mem[16'h0202] = 16'hCCCC;
      mem[16'h0203] = 16'hDDDD;
      for (int i = 0; i < 4; i++) mem[16'h0300 + 16'(i)] = 16'hFFFF;

      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);

      // Store
      drive_start(1'b0, 16'h0100, 64'h4444_3333_2222_1111, 64'd0);
      wait_done(1, lat);
      chk("st_latency", 64'(lat), 64'd5);
      chk("st_wq_drained", 64'(wq.size()), 64'd0);
      @(negedge clk);
      chk("idle_busy", 64'(busy), 64'd0);
      chk("idle_done", 64'(done), 64'd0);

      // Load
      drive_start(1'b1, 16'h0200, 64'd0, 64'hDDDD_CCCC_BBBB_AAAA);
      wait_done(1, lat);
      chk("ld_latency", 64'(lat), 64'd6);
      @(negedge clk);
      chk("ld_rdata_held", rdata, 64'hDDDD_CCCC_BBBB_AAAA);

      // Address wrap, then read the wrapped words back
      drive_start(1'b0, 16'hFFFE, 64'h8888_7777_6666_5555, 64'd0);
      wait_done(1, lat);
      chk("wrap_latency", 64'(lat), 64'd5);
      chk("rdata_untouched_by_store", rdata, 64'hDDDD_CCCC_BBBB_AAAA);
      @(negedge clk);
      drive_start(1'b1, 16'hFFFE, 64'd0, 64'h8888_7777_6666_5555);
      wait_done(1, lat);
      chk("wrap_ld_latency", 64'(lat), 64'd6);
      @(negedge clk);

      // Start pulsed during XFER must be ignored
      drive_start(1'b0, 16'h0500, 64'h0D0C_0B0A_0908_0706, 64'd0);
      @(negedge clk);
      start     = 1'b1;
      is_load   = 1'b0;
      base_addr = 16'h0600;
      wdata     = 64'h1;
      @(negedge clk);
      start = 1'b0;
      wait_done(3, lat);
      chk("ign_latency", 64'(lat), 64'd5);
      repeat (8) @(negedge clk);
      chk("ign_idle_busy", 64'(busy), 64'd0);
      chk("ign_xq_empty", 64'(xq.size()), 64'd0);

      // Back-to-back: store -> load -> store, each started in the DONE cycle
      drive_start(1'b0, 16'h0700, 64'hFACE_CAFE_BEEF_F00D, 64'd0);
      wait_done(1, lat);
      chk("b2b_st_latency", 64'(lat), 64'd5);
      drive_start(1'b1, 16'h0700, 64'd0, 64'hFACE_CAFE_BEEF_F00D);
      wait_done(1, lat);
      chk("b2b_ld_latency", 64'(lat), 64'd6);
      drive_start(1'b0, 16'h0710, 64'h0123_4567_89AB_CDEF, 64'd0);
      wait_done(1, lat);
      chk("b2b_st2_latency", 64'(lat), 64'd5);
      @(negedge clk);

      // Reset after the second write of a store
      drive_start(1'b0, 16'h0300, 64'h3333_2222_1111_0000, 64'd0);
      @(posedge clk);
      @(posedge clk);
      #1 reset = 1'b1;
      #1;
      chk("mid_rst_we",    64'(mem_we), 64'd0);
      chk("mid_rst_busy",  64'(busy), 64'd0);
      chk("mid_rst_addr",  64'(mem_addr), 64'd0);
      chk("mid_rst_rdata", rdata, 64'd0);
      wq.delete();
      xq.delete();
      repeat (3) @(negedge clk);
      chk("mid_rst_busy_hold", 64'(busy), 64'd0);
      chk("kept_word0", 64'(mem[16'h0300]), 64'h0000);
      chk("kept_word1", 64'(mem[16'h0301]), 64'h1111);
      chk("unwritten_word2", 64'(mem[16'h0302]), 64'hFFFF);
      chk("unwritten_word3", 64'(mem[16'h0303]), 64'hFFFF);
      reset = 1'b0;
      @(negedge clk);
      drive_start(1'b0, 16'h0304, 64'h7A7A_6B6B_5C5C_4D4D, 64'd0);
      wait_done(1, lat);
      chk("post_rst_latency", 64'(lat), 64'd5);
      @(negedge clk);

      // Inputs changing after accept must not affect the transfer
      drive_start(1'b0, 16'h0800, 64'h9999_AAAA_BBBB_CCCC, 64'd0);
      base_addr = 16'h0900;
      wdata     = 64'h0;
      is_load   = 1'b1;
      wait_done(1, lat);
      chk("stab_latency", 64'(lat), 64'd5);
      @(negedge clk);
      drive_start(1'b1, 16'h0800, 64'd0, 64'h9999_AAAA_BBBB_CCCC);
      wait_done(1, lat);
      chk("stab_ld_latency", 64'(lat), 64'd6);

      repeat (3) @(negedge clk);
      chk("final_wq_empty", 64'(wq.size()), 64'd0);
      chk("final_xq_empty", 64'(xq.size()), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
